viterbi_acs4: RTL
=================

# viterbi_acs4

Four-state add-compare-select (ACS) stage with path-metric storage for the K=3, rate-1/2 (generators 7,5 octal) Viterbi decoder. It sits directly downstream of the branch-metric calculators. Per received symbol it consumes the four 2-bit Hamming branch metrics, updates four path metrics, and emits one survivor decision bit per state plus the current best state. Its outputs go to the traceback/survivor memory stage.

## Interface

Parameters:
- PM_W, 6, path-metric width in bits; legal range 5..10.
- INIT_PM, 16, initial metric for states 1..3; must be < 2^(PM_W-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  synchronous re-initialisation of the path metrics (frame start).
- in_valid  input  1  branch metrics valid this cycle; one symbol per asserted cycle.
- bm_00, bm_01, bm_10, bm_11  input  2 each  Hamming distance (0..2) of the received pair to expected symbol {c1,c0}.
- out_valid  output  1  registered; high for one cycle per consumed symbol.
- dec  output  4  survivor decision, bit s for state s.
- best_state  output  2  index of the minimum new path metric.
- best_pm  output  PM_W  value of that minimum metric.
- norm_pulse  output  1  high with out_valid when normalisation was applied.

## Operation

- State encoding: s = {s1,s0}, where s1 is the most recent input bit. Predecessors of state {u,s1} are P0={s1,0} and P1={s1,1}.
- Per-state candidates (old metric + branch metric):
  - State 0: pm0+bm_00 | pm1+bm_11.
  - State 1: pm2+bm_10 | pm3+bm_01.
  - State 2: pm0+bm_11 | pm1+bm_00.
  - State 3: pm2+bm_01 | pm3+bm_10.
- Compare: dec[s]=1 only when the P1 candidate is strictly smaller. A tie selects P0 (dec=0).
- Add width is PM_W+1 internally. The result stored after normalisation/saturation is PM_W bits.
- best_state is the argmin of the four new metrics. Ties go to the lowest index.
- start applies in either of two ways:
  - Alone: pm0←0, pm1..pm3←INIT_PM, and no output.
  - Together with in_valid: the symbol is processed using the init values as the old metrics.
- in_valid low: metrics hold, and out_valid=0 on the next cycle.
- rst (any time, including mid-frame): pm0=0, pm1..3=INIT_PM. All outputs are 0: out_valid, dec, best_state, best_pm, norm_pulse.

## Timing

- Latency is 1 cycle. An in_valid sampled at edge n updates the metric registers at edge n. dec, best_state, best_pm, norm_pulse and out_valid are registered at the same edge and are visible during cycle n+1.
- Back-to-back in_valid is supported at full rate, one symbol per clock.
- Outputs other than out_valid hold their last value while out_valid=0.
- There is no backpressure; the consumer must accept every out_valid pulse.

## Configuration

- ACS_NORM_EN defined:
  - If all four new metrics have their MSB set, the MSB of each is cleared (subtract 2^(PM_W-1)) before storing.
  - norm_pulse=1 with that out_valid.
  - best_pm reports the normalised value.
  - Decisions are unaffected.
- ACS_NORM_EN undefined:
  - No normalisation; each new metric saturates at 2^PM_W−1.
  - norm_pulse is tied to 0.

## Test plan

- Reset values: assert rst mid-stream → all outputs 0 immediately; the internal metrics read back as 0/16/16/16 through a following symbol.
- First error-free symbol: after reset, in_valid with bm_00=0, bm_01=1, bm_10=1, bm_11=2 → next cycle out_valid=1, dec=4'b0000, best_state=0, best_pm=0. The new metrics are 0/17/2/17.
- Tie and strict-less: force pm0=pm1 via a sequence, then give equal candidates → dec[0]=0. Make the P1 candidate smaller by 1 → dec[0]=1.
- Normalisation (ACS_NORM_EN): hold in_valid with all bm=2 → on the update where all new metrics ≥32, norm_pulse=1 and the stored metrics drop by 32. Without the macro, the metrics saturate at 63 and norm_pulse stays 0.
- start with in_valid: mid-frame, assert start+in_valid with bm_00=0 → metrics are computed from 0/16/16/16 and best_pm=0. start alone → out_valid stays 0 next cycle.
- Gapped input: alternate in_valid 1/0 for 8 symbols → exactly 8 out_valid pulses, each one cycle after its symbol, with metrics unchanged during the gaps.

Source files
------------

// File: rtl/viterbi_acs4.sv
// Four-state add-compare-select stage for the K=3 (7,5) Viterbi decoder; one symbol per clock, 1-cycle latency, no backpressure.
// Optional path-metric normalisation is enabled by defining ACS_NORM_EN; otherwise metrics saturate at the top of the range.
module viterbi_acs4 #(
    parameter int PM_W    = 6,
    parameter int INIT_PM = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [1:0]      bm_00,
    input  logic [1:0]      bm_01,
    input  logic [1:0]      bm_10,
    input  logic [1:0]      bm_11,
    output logic            out_valid,
    output logic [3:0]      dec,
    output logic [1:0]      best_state,
    output logic [PM_W-1:0] best_pm,
    output logic            norm_pulse
);

    localparam logic [PM_W:0]   MAX_PM = {1'b0, {PM_W{1'b1}}};
    localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

    logic [3:0][PM_W-1:0] pm_q;
    logic [3:0][PM_W-1:0] pm_old;
    logic [3:0][PM_W-1:0] pm_new;
    logic [3:0][1:0]      bm;
    logic [3:0][PM_W:0]   cand0;
    logic [3:0][PM_W:0]   cand1;
    logic [3:0][PM_W:0]   surv;
    logic [3:0]           dec_c;
    logic [1:0]           best_c;
    logic [PM_W-1:0]      best_pm_c;

    function automatic logic [PM_W:0] acs_add(input logic [PM_W-1:0] pm, input logic [1:0] b);
        acs_add = {1'b0, pm} + {{(PM_W-1){1'b0}}, b};
    endfunction

    function automatic logic [PM_W-1:0] sat(input logic [PM_W:0] v);
        sat = (v > MAX_PM) ? MAX_PM[PM_W-1:0] : v[PM_W-1:0];
    endfunction

    // A frame start coinciding with a symbol uses the init metrics as the old metrics.
    assign pm_old = start ? {INIT_V, INIT_V, INIT_V, {PM_W{1'b0}}} : pm_q;
    assign bm     = {bm_11, bm_10, bm_01, bm_00};

    always_comb begin
        cand0[0] = acs_add(pm_old[0], bm[0]);
        cand1[0] = acs_add(pm_old[1], bm[3]);
        cand0[1] = acs_add(pm_old[2], bm[2]);
        cand1[1] = acs_add(pm_old[3], bm[1]);
        cand0[2] = acs_add(pm_old[0], bm[3]);
        cand1[2] = acs_add(pm_old[1], bm[0]);
        cand0[3] = acs_add(pm_old[2], bm[1]);
        cand1[3] = acs_add(pm_old[3], bm[2]);
        for (int s = 0; s < 4; s++) begin
            dec_c[s] = cand1[s] < cand0[s];
            surv[s]  = dec_c[s] ? cand1[s] : cand0[s];
        end
    end

`ifdef ACS_NORM_EN
    localparam logic [PM_W:0] HALF = {2'b01, {(PM_W-1){1'b0}}};
    logic norm_c;
    logic norm_q;

    always_comb begin
        norm_c = 1'b1;
        for (int s = 0; s < 4; s++) begin
            if (surv[s] < HALF) norm_c = 1'b0;
        end
        // Saturation stays as an overflow guard; with normalisation active it should never bite.
        for (int s = 0; s < 4; s++) begin
            pm_new[s] = sat(norm_c ? (surv[s] - HALF) : surv[s]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            norm_q <= 1'b0;
        end else if (in_valid) begin
            norm_q <= norm_c;
        end
    end

    assign norm_pulse = norm_q;
`else
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            pm_new[s] = sat(surv[s]);
        end
    end

    assign norm_pulse = 1'b0;
`endif

    always_comb begin
        best_c    = 2'd0;
        best_pm_c = pm_new[0];
        for (int s = 1; s < 4; s++) begin
            if (pm_new[s] < best_pm_c) begin
                best_c    = 2'(s);
                best_pm_c = pm_new[s];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pm_q       <= {INIT_V, INIT_V, INIT_V, {PM_W{1'b0}}};
            out_valid  <= 1'b0;
            dec        <= 4'd0;
            best_state <= 2'd0;
            best_pm    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                pm_q       <= pm_new;
                dec        <= dec_c;
                best_state <= best_c;
                best_pm    <= best_pm_c;
            end else if (start) begin
                pm_q <= pm_old;
            end
        end
    end

endmodule
